// File: rtl/id_stage_pipelined_if.sv
// -----------------------------------------------------------------------------
// id_stage_pipelined_if
// Bundles every non-clock signal of the MIPS decode stage.
//   master : upstream/downstream side (drives IF/ID, EX/MEM hazard info and
//            write-back; receives Stall, Redirect and the ID/EX bundle)
//   slave  : the decode stage itself
// Parameters: XLEN (datapath width), RA_W (register address width).
// -----------------------------------------------------------------------------
interface id_stage_pipelined_if #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
);
   // IF/ID slot
   logic            IFID_Valid;
   logic [31:0]     IFID_Instruction;
   logic [XLEN-1:0] IFID_PC_plus_4;
   // EX/MEM hazard information
   logic            EXMEM_RegWrite;
   logic            EXMEM_MemRead;
   logic [RA_W-1:0] EXMEM_Dst;
   // write-back port into the register file
   logic            WB_RegWrite;
   logic [RA_W-1:0] WB_Addr;
   logic [XLEN-1:0] WB_Data;
   // combinational control back to fetch
   logic            Stall;
   logic            Redirect;
   logic [XLEN-1:0] Redirect_PC;
   // registered ID/EX bundle
   logic            IDEX_Valid;
   logic            IDEX_ALUSrc;
   logic            IDEX_RegDst;
   logic            IDEX_MemWrite;
   logic            IDEX_MemRead;
   logic            IDEX_MemToReg;
   logic            IDEX_RegWrite;
   logic [2:0]      IDEX_ALUControl;
   logic [XLEN-1:0] IDEX_ReadData1;
   logic [XLEN-1:0] IDEX_ReadData2;
   logic [XLEN-1:0] IDEX_Imm;
   logic [RA_W-1:0] IDEX_Rs;
   logic [RA_W-1:0] IDEX_Rt;
   logic [RA_W-1:0] IDEX_Rd;
   logic            Illegal;

   modport master (
      output IFID_Valid, IFID_Instruction, IFID_PC_plus_4,
             EXMEM_RegWrite, EXMEM_MemRead, EXMEM_Dst,
             WB_RegWrite, WB_Addr, WB_Data,
      input  Stall, Redirect, Redirect_PC,
             IDEX_Valid, IDEX_ALUSrc, IDEX_RegDst, IDEX_MemWrite, IDEX_MemRead,
             IDEX_MemToReg, IDEX_RegWrite, IDEX_ALUControl,
             IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm,
             IDEX_Rs, IDEX_Rt, IDEX_Rd, Illegal
   );

   modport slave (
      input  IFID_Valid, IFID_Instruction, IFID_PC_plus_4,
             EXMEM_RegWrite, EXMEM_MemRead, EXMEM_Dst,
             WB_RegWrite, WB_Addr, WB_Data,
      output Stall, Redirect, Redirect_PC,
             IDEX_Valid, IDEX_ALUSrc, IDEX_RegDst, IDEX_MemWrite, IDEX_MemRead,
             IDEX_MemToReg, IDEX_RegWrite, IDEX_ALUControl,
             IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm,
             IDEX_Rs, IDEX_Rt, IDEX_Rd, Illegal
   );
endinterface

// File: rtl/id_stage_pipelined.sv
// -----------------------------------------------------------------------------
// id_stage_pipelined
// MIPS decode stage: decodes the IF/ID instruction, reads the internal
// register file, resolves beq/bne/j in ID, detects load-use and
// branch-operand hazards and registers the ID/EX bundle.
// Ports:
//   Clk   : rising-edge clock
//   Rst_n : asynchronous active-low reset (clears ID/EX, Illegal and the RF)
//   bus   : id_stage_pipelined_if.slave (IF/ID, EX/MEM, WB in; Stall,
//           Redirect, Redirect_PC and IDEX_*/Illegal out)
// Configuration macro: ID_RF_BYPASS_EN
//   defined   : a same-cycle WB write is bypassed to the ID read
//   undefined : the read stalls one cycle and picks up the written value
// -----------------------------------------------------------------------------
module id_stage_pipelined #(
   parameter int XLEN     = 32,
   parameter int RF_DEPTH = 32,
   parameter int RA_W     = 5
) (
   input logic                 Clk,
   input logic                 Rst_n,
   id_stage_pipelined_if.slave bus
);
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                          OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                          OP_J = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                          FN_OR = 6'h25, FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010,
      ALU_SUB = 3'b110, ALU_SLT = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic    alu_src;
      logic    reg_dst;
      logic    mem_write;
      logic    mem_read;
      logic    mem_to_reg;
      logic    reg_write;
      alu_op_e alu_control;
   } ctl_t;

   typedef struct packed {
      logic            valid;
      ctl_t            ctl;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [RA_W-1:0] rs;
      logic [RA_W-1:0] rt;
      logic [RA_W-1:0] rd;
   } idex_t;

   // instruction fields
   logic [31:0]     instr;
   logic [5:0]      op, funct;
   logic [RA_W-1:0] rs, rt, rd;
   logic [XLEN-1:0] imm_ext;

   assign instr   = bus.IFID_Instruction;
   assign op      = instr[31:26];
   assign funct   = instr[5:0];
   assign rs      = RA_W'(instr[25:21]);
   assign rt      = RA_W'(instr[20:16]);
   assign rd      = RA_W'(instr[15:11]);
   assign imm_ext = {{(XLEN-16){instr[15]}}, instr[15:0]};

   // ---------------- decode ----------------
   ctl_t ctl;
   logic uses_rs, uses_rt, is_beq, is_bne, is_j, illegal;

   // NOTE: every output of this block is defaulted first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      ctl     = '0;
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      is_beq  = 1'b0;
      is_bne  = 1'b0;
      is_j    = 1'b0;
      illegal = 1'b0;
      case (op)
         OP_RTYPE: begin
            uses_rs       = 1'b1;
            uses_rt       = 1'b1;
            ctl.reg_dst   = 1'b1;
            ctl.reg_write = 1'b1;
            case (funct)
               FN_ADD:  ctl.alu_control = ALU_ADD;
               FN_SUB:  ctl.alu_control = ALU_SUB;
               FN_AND:  ctl.alu_control = ALU_AND;
               FN_OR:   ctl.alu_control = ALU_OR;
               FN_SLT:  ctl.alu_control = ALU_SLT;
               default: illegal = 1'b1;
            endcase
         end
         OP_LW: begin
            uses_rs          = 1'b1;
            ctl.alu_src      = 1'b1;
            ctl.mem_read     = 1'b1;
            ctl.mem_to_reg   = 1'b1;
            ctl.reg_write    = 1'b1;
            ctl.alu_control  = ALU_ADD;
         end
         OP_SW: begin
            uses_rs          = 1'b1;
            uses_rt          = 1'b1;
            ctl.alu_src      = 1'b1;
            ctl.mem_write    = 1'b1;
            ctl.alu_control  = ALU_ADD;
         end
         OP_ADDI: begin
            uses_rs          = 1'b1;
            ctl.alu_src      = 1'b1;
            ctl.reg_write    = 1'b1;
            ctl.alu_control  = ALU_ADD;
         end
         // branches and jumps complete in ID and travel on with no controls
         OP_BEQ: begin uses_rs = 1'b1; uses_rt = 1'b1; is_beq = 1'b1; end
         OP_BNE: begin uses_rs = 1'b1; uses_rt = 1'b1; is_bne = 1'b1; end
         OP_J:   is_j = 1'b1;
         default: illegal = 1'b1;
      endcase
      if (illegal) begin
         ctl     = '0;
         uses_rs = 1'b0;
         uses_rt = 1'b0;
      end
   end

   // ---------------- register file ----------------
   logic [XLEN-1:0] rf_q [RF_DEPTH];
   logic [XLEN-1:0] rf_d [RF_DEPTH];
   logic [XLEN-1:0] rf_rs, rf_rt, rd1, rd2;
   logic            wb_hit_rs, wb_hit_rt;

   always_comb begin
      rf_d = rf_q;
      if (bus.WB_RegWrite && bus.WB_Addr != '0)
         rf_d[bus.WB_Addr] = bus.WB_Data;
   end

   // r0 and any address past the implemented depth read as zero
   assign rf_rs = (rs == '0 || int'(rs) >= RF_DEPTH) ? '0 : rf_q[rs];
   assign rf_rt = (rt == '0 || int'(rt) >= RF_DEPTH) ? '0 : rf_q[rt];

   assign wb_hit_rs = bus.WB_RegWrite && bus.WB_Addr != '0 && bus.WB_Addr == rs;
   assign wb_hit_rt = bus.WB_RegWrite && bus.WB_Addr != '0 && bus.WB_Addr == rt;

`ifdef ID_RF_BYPASS_EN
   assign rd1 = wb_hit_rs ? bus.WB_Data : rf_rs;
   assign rd2 = wb_hit_rt ? bus.WB_Data : rf_rt;
`else
   assign rd1 = rf_rs;
   assign rd2 = rf_rt;
`endif

   // ---------------- hazards ----------------
   idex_t           idex_q, idex_d;
   logic            illegal_q, illegal_d;
   logic [RA_W-1:0] idex_dst;
   logic            load_use, br_haz, wb_haz, stall, taken;

   assign idex_dst = idex_q.ctl.reg_dst ? idex_q.rd : idex_q.rt;

   assign load_use = bus.IFID_Valid && idex_q.valid && idex_q.ctl.mem_read &&
                     idex_q.rt != '0 &&
                     ((uses_rs && rs == idex_q.rt) || (uses_rt && rt == idex_q.rt));

   // Branch operands are compared in ID, so any pending producer in ID/EX or
   // EX/MEM (load or ALU result, nothing is forwarded) must drain first.
   assign br_haz = bus.IFID_Valid && (is_beq || is_bne) &&
                   ((idex_q.ctl.reg_write && idex_dst != '0 &&
                     (rs == idex_dst || rt == idex_dst)) ||
                    ((bus.EXMEM_RegWrite || bus.EXMEM_MemRead) && bus.EXMEM_Dst != '0 &&
                     (rs == bus.EXMEM_Dst || rt == bus.EXMEM_Dst)));

`ifdef ID_RF_BYPASS_EN
   assign wb_haz = 1'b0;
`else
   assign wb_haz = bus.IFID_Valid && ((uses_rs && wb_hit_rs) || (uses_rt && wb_hit_rt));
`endif

   assign stall = load_use || br_haz || wb_haz;
   assign taken = is_j || (is_beq && rd1 == rd2) || (is_bne && rd1 != rd2);

   assign bus.Stall       = stall;
   assign bus.Redirect    = bus.IFID_Valid && !stall && taken;
   assign bus.Redirect_PC = is_j ? {bus.IFID_PC_plus_4[XLEN-1:28], instr[25:0], 2'b00}
                                 : bus.IFID_PC_plus_4 + (imm_ext << 2);

   // ---------------- ID/EX bundle ----------------
   always_comb begin
      idex_d    = '0;
      illegal_d = 1'b0;
      if (bus.IFID_Valid && !stall) begin
         illegal_d = illegal;
         if (!illegal) begin
            idex_d.valid = 1'b1;
            idex_d.ctl   = ctl;
            idex_d.rd1   = rd1;
            idex_d.rd2   = rd2;
            idex_d.imm   = imm_ext;
            idex_d.rs    = rs;
            idex_d.rt    = rt;
            idex_d.rd    = rd;
         end
      end
   end

   // NOTE: the register file is cleared on reset, so it is built from
   // resettable flops rather than an inferred RAM macro.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         idex_q    <= '0;
         illegal_q <= 1'b0;
         rf_q      <= '{default: '0};
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling the
         // pre-edge values regardless of statement order.
         idex_q    <= idex_d;
         illegal_q <= illegal_d;
         rf_q      <= rf_d;
      end
   end

   assign bus.IDEX_Valid      = idex_q.valid;
   assign bus.IDEX_ALUSrc     = idex_q.ctl.alu_src;
   assign bus.IDEX_RegDst     = idex_q.ctl.reg_dst;
   assign bus.IDEX_MemWrite   = idex_q.ctl.mem_write;
   assign bus.IDEX_MemRead    = idex_q.ctl.mem_read;
   assign bus.IDEX_MemToReg   = idex_q.ctl.mem_to_reg;
   assign bus.IDEX_RegWrite   = idex_q.ctl.reg_write;
   assign bus.IDEX_ALUControl = idex_q.ctl.alu_control;
   assign bus.IDEX_ReadData1  = idex_q.rd1;
   assign bus.IDEX_ReadData2  = idex_q.rd2;
   assign bus.IDEX_Imm        = idex_q.imm;
   assign bus.IDEX_Rs         = idex_q.rs;
   assign bus.IDEX_Rt         = idex_q.rt;
   assign bus.IDEX_Rd         = idex_q.rd;
   assign bus.Illegal         = illegal_q;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipelined
// Directed bench for id_stage_pipelined: decode, register file, load-use and
// branch hazards, redirect targets, write-back collision, illegal opcodes and
// asynchronous reset. Inputs change 1 time unit after a rising edge;
// combinational outputs are checked after a settle delay, registered outputs
// after the following edge. Expectations for the write-back collision follow
// ID_RF_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_id_stage_pipelined;
   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   id_stage_pipelined_if #(.XLEN(32), .RA_W(5)) bus ();

   id_stage_pipelined #(.XLEN(32), .RF_DEPTH(32), .RA_W(5)) u_dut (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                         input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt,
                                         input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc4);
      bus.IFID_Valid       = 1'b1;
      bus.IFID_Instruction = ins;
      bus.IFID_PC_plus_4   = pc4;
   endtask

   task automatic wb(input logic en, input int addr, input logic [31:0] data);
      bus.WB_RegWrite = en;
      bus.WB_Addr     = 5'(addr);
      bus.WB_Data     = data;
   endtask

   initial begin
      rst_n                = 1'b0;
      bus.IFID_Valid       = 1'b0;
      bus.IFID_Instruction = 32'd0;
      bus.IFID_PC_plus_4   = 32'd0;
      bus.EXMEM_RegWrite   = 1'b0;
      bus.EXMEM_MemRead    = 1'b0;
      bus.EXMEM_Dst        = 5'd0;
      wb(1'b0, 0, 32'd0);

      // reset state
      #12;
      check("rst_valid",    32'(bus.IDEX_Valid), 32'd0);
      check("rst_regwrite", 32'(bus.IDEX_RegWrite), 32'd0);
      check("rst_illegal",  32'(bus.Illegal), 32'd0);
      check("rst_rd1",      bus.IDEX_ReadData1, 32'd0);
      rst_n = 1'b1;
      step();

      // write r5 then add r3,r5,r5
      wb(1'b1, 5, 32'h1234);
      step();
      wb(1'b0, 0, 32'd0);
      drive(r_ins(5, 5, 3, 6'h20), 32'h40);
      settle();
      check("add_stall", 32'(bus.Stall), 32'd0);
      step();
      check("add_rd1",    bus.IDEX_ReadData1, 32'h1234);
      check("add_rd2",    bus.IDEX_ReadData2, 32'h1234);
      check("add_alu",    32'(bus.IDEX_ALUControl), 32'b010);
      check("add_regdst", 32'(bus.IDEX_RegDst), 32'd1);
      check("add_regwr",  32'(bus.IDEX_RegWrite), 32'd1);
      check("add_rd",     32'(bus.IDEX_Rd), 32'd3);

      // addi r8,r0,-1: sign extension, immediate source
      drive(i_ins(6'h08, 0, 8, 16'hFFFF), 32'h44);
      step();
      check("addi_imm",    bus.IDEX_Imm, 32'hFFFF_FFFF);
      check("addi_alusrc", 32'(bus.IDEX_ALUSrc), 32'd1);
      check("addi_regdst", 32'(bus.IDEX_RegDst), 32'd0);

      // sub r9,r5,r0
      drive(r_ins(5, 0, 9, 6'h22), 32'h48);
      step();
      check("sub_alu", 32'(bus.IDEX_ALUControl), 32'b110);
      check("sub_rd2", bus.IDEX_ReadData2, 32'd0);

      // lw r2,0(r1) followed by add r4,r2,r2: one stall, one bubble
      drive(i_ins(6'h23, 1, 2, 16'h0000), 32'h4C);
      step();
      check("lw_memread", 32'(bus.IDEX_MemRead), 32'd1);
      check("lw_mem2reg", 32'(bus.IDEX_MemToReg), 32'd1);
      check("lw_rt",      32'(bus.IDEX_Rt), 32'd2);
      drive(r_ins(2, 2, 4, 6'h20), 32'h50);
      settle();
      check("lu_stall",    32'(bus.Stall), 32'd1);
      check("lu_redirect", 32'(bus.Redirect), 32'd0);
      step();
      check("lu_bubble_valid", 32'(bus.IDEX_Valid), 32'd0);
      check("lu_bubble_regwr", 32'(bus.IDEX_RegWrite), 32'd0);
      settle();
      check("lu_stall_drop", 32'(bus.Stall), 32'd0);
      step();
      check("lu_issue_valid", 32'(bus.IDEX_Valid), 32'd1);
      check("lu_issue_rd",    32'(bus.IDEX_Rd), 32'd4);

      // load into r0 never causes a load-use stall
      drive(i_ins(6'h23, 1, 0, 16'h0000), 32'h54);
      step();
      drive(r_ins(0, 0, 4, 6'h20), 32'h58);
      settle();
      check("lu_r0_stall", 32'(bus.Stall), 32'd0);
      step();

      // r1=r2=7, then beq/bne at PC+4=0x100
      bus.IFID_Valid = 1'b0;
      wb(1'b1, 1, 32'd7);
      step();
      wb(1'b1, 2, 32'd7);
      step();
      wb(1'b0, 0, 32'd0);
      drive(i_ins(6'h04, 1, 2, 16'd3), 32'h100);
      settle();
      check("beq_stall",    32'(bus.Stall), 32'd0);
      check("beq_redirect", 32'(bus.Redirect), 32'd1);
      check("beq_target",   bus.Redirect_PC, 32'h10C);
      drive(i_ins(6'h04, 1, 2, 16'hFFFF), 32'h100);
      settle();
      check("beq_neg_target", bus.Redirect_PC, 32'hFC);
      drive(i_ins(6'h04, 1, 2, 16'd3), 32'h100);
      bus.EXMEM_RegWrite = 1'b1;
      bus.EXMEM_Dst      = 5'd2;
      settle();
      check("br_exmem_alu_stall", 32'(bus.Stall), 32'd1);
      check("br_exmem_alu_redir", 32'(bus.Redirect), 32'd0);
      bus.EXMEM_RegWrite = 1'b0;
      bus.EXMEM_MemRead  = 1'b1;
      bus.EXMEM_Dst      = 5'd1;
      settle();
      check("br_exmem_ld_stall", 32'(bus.Stall), 32'd1);
      bus.EXMEM_Dst = 5'd0;
      settle();
      check("br_exmem_r0_stall", 32'(bus.Stall), 32'd0);
      check("br_exmem_r0_redir", 32'(bus.Redirect), 32'd1);
      bus.EXMEM_MemRead = 1'b0;
      drive(i_ins(6'h05, 1, 2, 16'd3), 32'h100);
      settle();
      check("bne_redirect", 32'(bus.Redirect), 32'd0);
      step();
      check("bne_idex_valid", 32'(bus.IDEX_Valid), 32'd1);
      check("bne_idex_regwr", 32'(bus.IDEX_RegWrite), 32'd0);

      // addi r1 in ID/EX blocks a following beq on r1
      drive(i_ins(6'h08, 0, 1, 16'd5), 32'h104);
      step();
      drive(i_ins(6'h04, 1, 2, 16'd3), 32'h108);
      settle();
      check("br_idex_stall", 32'(bus.Stall), 32'd1);
      check("br_idex_redir", 32'(bus.Redirect), 32'd0);
      step();

      // j 0x0040000 with PC+4=0x10000004
      drive({6'h02, 26'h0040000}, 32'h1000_0004);
      settle();
      check("j_redirect", 32'(bus.Redirect), 32'd1);
      check("j_target",   bus.Redirect_PC, 32'h1010_0000);
      step();
      check("j_idex_valid", 32'(bus.IDEX_Valid), 32'd1);

      // WB r6=9 while ID reads r6 (add r7,r6,r0)
      wb(1'b1, 6, 32'd9);
      drive(r_ins(6, 0, 7, 6'h20), 32'h200);
      settle();
`ifdef ID_RF_BYPASS_EN
      check("wbcol_stall", 32'(bus.Stall), 32'd0);
      step();
      wb(1'b0, 0, 32'd0);
      check("wbcol_rd1", bus.IDEX_ReadData1, 32'd9);
`else
      check("wbcol_stall", 32'(bus.Stall), 32'd1);
      step();
      wb(1'b0, 0, 32'd0);
      check("wbcol_bubble", 32'(bus.IDEX_Valid), 32'd0);
      settle();
      check("wbcol_stall_drop", 32'(bus.Stall), 32'd0);
      step();
      check("wbcol_rd1", bus.IDEX_ReadData1, 32'd9);
`endif

      // unsupported opcode, then unsupported funct
      drive({6'h3F, 26'd0}, 32'h204);
      step();
      check("ill_op_valid",   32'(bus.IDEX_Valid), 32'd0);
      check("ill_op_regwr",   32'(bus.IDEX_RegWrite), 32'd0);
      check("ill_op_memread", 32'(bus.IDEX_MemRead), 32'd0);
      check("ill_op_flag",    32'(bus.Illegal), 32'd1);
      bus.IFID_Valid = 1'b0;
      step();
      check("ill_op_clear", 32'(bus.Illegal), 32'd0);
      drive(r_ins(1, 2, 3, 6'h3F), 32'h208);
      step();
      check("ill_fn_flag",  32'(bus.Illegal), 32'd1);
      check("ill_fn_valid", 32'(bus.IDEX_Valid), 32'd0);

      // reset in the middle of a load-use stall
      drive(i_ins(6'h23, 1, 2, 16'h0000), 32'h20C);
      step();
      drive(r_ins(2, 2, 4, 6'h20), 32'h210);
      settle();
      check("mid_pre_stall", 32'(bus.Stall), 32'd1);
      rst_n = 1'b0;
      settle();
      check("mid_rst_stall",   32'(bus.Stall), 32'd0);
      check("mid_rst_valid",   32'(bus.IDEX_Valid), 32'd0);
      check("mid_rst_memread", 32'(bus.IDEX_MemRead), 32'd0);
      bus.IFID_Valid = 1'b0;
      rst_n = 1'b1;

      // every register reads back zero after reset
      for (int i = 1; i < 32; i++) begin
         drive(r_ins(i, i, 0, 6'h25), 32'h300);
         step();
         check($sformatf("rf_clear_r%0d", i), bus.IDEX_ReadData1, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
